rans_interleaved_enc: RTL and testbench

Multi-lane interleaved rANS encoder with standard pre-encode renormalisation, valid/ready streaming on both the symbol and byte sides, and a flush mode that serialises the final lane states.
Accepted symbols are dealt round-robin to LANES independent state registers, so a multi-state decoder can run lanes in parallel.
It sits between the symbol source (DMA/AXI-stream adapter) and the byte packer, and is the next-generation replacement for the single-state encoder.

---
 rtl/rans_interleaved_enc.sv | 258 +++++++++++++++++++++++++
 tb/tb_rans_interleaved_enc.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rans_interleaved_enc.sv
// rans_interleaved_enc: LANES-way interleaved rANS encoder with renorm and flush.
// Ports: s_* symbol in (valid/ready), freq_* table write, m_* byte out, done_o/err_o status.
module rans_interleaved_enc #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int SHIFT_WIDTH  = 4,
  parameter int LANES        = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [SYMBOL_WIDTH-1:0] s_symb_i,
  input  logic                    flush_i,
  input  logic                    freq_wr_i,
  input  logic [SYMBOL_WIDTH-1:0] freq_addr_i,
  input  logic [RESOLUTION-1:0]   freq_i,
  input  logic [RESOLUTION-1:0]   cum_freq_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [SYMBOL_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int M  = 1 << RESOLUTION;
  localparam int SW = RESOLUTION + SYMBOL_WIDTH;
  localparam int NB = (SW + SYMBOL_WIDTH - 1) / SYMBOL_WIDTH;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW = SW + 1;
  localparam int EW = SHIFT_WIDTH + RW;
  localparam int TD = 1 << SYMBOL_WIDTH;
  localparam int PW = 2 * SW + 1;

  localparam logic [SW-1:0] L_MIN     = SW'(M);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RENORM,
    ST_ENCODE,
    ST_FLUSH
  } state_e;

  // Reciprocal entry {shift, rcp}: shift = ceil(log2 f),
  // rcp = floor(2^(SW+shift)/f). The quotient estimate
  // is then low by at most one for any x < 2^SW.
  function automatic logic [EW-1:0] rom_entry(input int f);
    int s;
    longint unsigned r;
    s = 0;
    for (int k = 0; k <= RESOLUTION; k++)
      if ((1 << k) < f) s = k + 1;
    if (f == 0) r = 64'd0;
    else r = (64'd1 << (SW + s)) / longint'(unsigned'(f));
    return {SHIFT_WIDTH'(s), RW'(r)};
  endfunction

  function automatic logic [SYMBOL_WIDTH-1:0] flush_byte(
    input logic [SW-1:0] x,
    input logic [BW-1:0] idx
  );
    logic [NB*SYMBOL_WIDTH-1:0] p;
    p = '0;
    p[SW-1:0] = x;
    return p[idx*SYMBOL_WIDTH +: SYMBOL_WIDTH];
  endfunction

  logic [EW-1:0] rom [M];

  for (genvar i = 0; i < M; i++) begin : g_rom
    localparam logic [EW-1:0] ENT = rom_entry(i);
    assign rom[i] = ENT;
  end

  // {f, c} per symbol; RAM, deliberately not reset
  logic [2*RESOLUTION-1:0] ftab [TD];

  always_ff @(posedge clk_i) begin
    if (freq_wr_i) ftab[freq_addr_i] <= {freq_i, cum_freq_i};
  end

  state_e                  st_q, st_d;
  logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;
  logic [RESOLUTION-1:0]   f_q, f_d;
  logic [RESOLUTION-1:0]   c_q, c_d;
  logic [SW-1:0]           x_q, x_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [SW-1:0]           state_q [LANES];
  logic [SW-1:0]           state_d [LANES];
  logic [LW-1:0]           fl_lane_q, fl_lane_d;
  logic [BW-1:0]           fl_byte_q, fl_byte_d;
  logic [SHIFT_WIDTH-1:0]  sh_q, sh_d;
  logic [RW-1:0]           rcp_q, rcp_d;
  logic                    m_valid_q, m_valid_d;
  logic [SYMBOL_WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  // x / f via reciprocal with one remainder correction
  logic [PW-1:0] prod;
  logic [PW-1:0] prod_sh;
  logic [SW-1:0] f_ext;
  logic [SW-1:0] q_est;
  logic [SW-1:0] r_est;
  logic [SW-1:0] q_fix;
  logic [SW-1:0] r_fix;
  logic [SW-1:0] enc_x;

  always_comb begin
    f_ext   = SW'(f_q);
    prod    = PW'(x_q) * PW'(rcp_q);
    prod_sh = (prod >> SW) >> sh_q;
    q_est   = SW'(prod_sh);
    r_est   = x_q - SW'(q_est * f_ext);
    q_fix   = q_est;
    r_fix   = r_est;
    if (r_est >= f_ext) begin
      q_fix = q_est + SW'(1);
      r_fix = r_est - f_ext;
    end
    enc_x = (q_fix << RESOLUTION) + r_fix + SW'(c_q);
  end

  assign s_ready_o = (st_q == ST_IDLE) && !flush_i;

  always_comb begin
    st_d      = st_q;
    sym_d     = sym_q;
    f_d       = f_q;
    c_d       = c_q;
    x_d       = x_q;
    lane_d    = lane_q;
    state_d   = state_q;
    fl_lane_d = fl_lane_q;
    fl_byte_d = fl_byte_q;
    {sh_d, rcp_d} = rom[f_q];
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (st_q)
      ST_IDLE: begin
        if (flush_i) begin
          st_d      = ST_FLUSH;
          fl_lane_d = LAST_LANE;
          fl_byte_d = '0;
          m_valid_d = 1'b1;
          m_data_d  = flush_byte(state_q[LAST_LANE], '0);
          m_last_d  = (LANES == 1) && (NB == 1);
        end else if (s_valid_i) begin
          sym_d = s_symb_i;
          st_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        {f_d, c_d} = ftab[sym_q];
        x_d        = state_q[lane_q];
        st_d       = ST_RENORM;
      end
      ST_RENORM: begin
        if (m_valid_q) begin
          if (m_ready_i) begin
            m_valid_d = 1'b0;
            x_d       = x_q >> SYMBOL_WIDTH;
          end
        end else if (f_q == '0) begin
          err_d = 1'b1;
          st_d  = ST_IDLE;
        end else if (x_q >= (f_ext << SYMBOL_WIDTH)) begin
          m_valid_d = 1'b1;
          m_data_d  = x_q[SYMBOL_WIDTH-1:0];
          m_last_d  = 1'b0;
        end else begin
          st_d = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        state_d[lane_q] = enc_x;
        lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + LW'(1);
        st_d   = ST_IDLE;
      end
      ST_FLUSH: begin
        if (m_ready_i) begin
          if (m_last_q) begin
            for (int i = 0; i < LANES; i++) state_d[i] = L_MIN;
            lane_d    = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            done_d    = 1'b1;
            st_d      = ST_IDLE;
          end else begin
            if (fl_byte_q == LAST_BYTE) begin
              fl_byte_d = '0;
              fl_lane_d = fl_lane_q - LW'(1);
            end else begin
              fl_byte_d = fl_byte_q + BW'(1);
            end
            m_data_d = flush_byte(state_q[fl_lane_d], fl_byte_d);
            m_last_d = (fl_lane_d == '0) && (fl_byte_d == LAST_BYTE);
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q      <= ST_IDLE;
      sym_q     <= '0;
      f_q       <= '0;
      c_q       <= '0;
      x_q       <= '0;
      lane_q    <= '0;
      for (int i = 0; i < LANES; i++) state_q[i] <= L_MIN;
      fl_lane_q <= '0;
      fl_byte_q <= '0;
      sh_q      <= '0;
      rcp_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      sym_q     <= sym_d;
      f_q       <= f_d;
      c_q       <= c_d;
      x_q       <= x_d;
      lane_q    <= lane_d;
      state_q   <= state_d;
      fl_lane_q <= fl_lane_d;
      fl_byte_q <= fl_byte_d;
      sh_q      <= sh_d;
      rcp_q     <= rcp_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_rans_interleaved_enc.sv
// tb_rans_interleaved_enc: scoreboard bench for rans_interleaved_enc.
// Arithmetic rANS model produces expected bytes; a monitor pops and compares.
module tb_rans_interleaved_enc;

  localparam int LANES = 4;
  localparam int NB    = 3;
  localparam int M     = 1024;

  logic       clk_i       = 1'b0;
  logic       rst_i       = 1'b1;
  logic       s_valid_i   = 1'b0;
  logic       s_ready_o;
  logic [7:0] s_symb_i    = '0;
  logic       flush_i     = 1'b0;
  logic       freq_wr_i   = 1'b0;
  logic [7:0] freq_addr_i = '0;
  logic [9:0] freq_i      = '0;
  logic [9:0] cum_freq_i  = '0;
  logic       m_valid_o;
  logic       m_ready_i   = 1'b1;
  logic [7:0] m_data_o;
  logic       m_last_o;
  logic       done_o;
  logic       err_o;

  rans_interleaved_enc dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_symb_i    (s_symb_i),
    .flush_i     (flush_i),
    .freq_wr_i   (freq_wr_i),
    .freq_addr_i (freq_addr_i),
    .freq_i      (freq_i),
    .cum_freq_i  (cum_freq_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;
  int unsigned lane_st[LANES];
  int          lptr = 0;
  int unsigned tf[256];
  int unsigned tc[256];
  int          err_exp = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // --- reference model: plain rANS arithmetic ---
  task automatic model_reset();
    for (int i = 0; i < LANES; i++) lane_st[i] = M;
    lptr    = 0;
    err_exp = 0;
    exp_q.delete();
  endtask

  task automatic model_sym(input int s);
    int unsigned x;
    int unsigned f;
    int unsigned c;
    exp_t e;
    f = tf[s];
    c = tc[s];
    if (f == 0) begin
      err_exp = 1;
      return;
    end
    x = lane_st[lptr];
    while (x >= f * 256) begin
      e.d = 8'(x % 256);
      e.l = 1'b0;
      exp_q.push_back(e);
      x = x / 256;
    end
    lane_st[lptr] = (x / f) * M + (x % f) + c;
    lptr = (lptr + 1) % LANES;
  endtask

  task automatic model_flush();
    exp_t e;
    for (int l = LANES - 1; l >= 0; l--)
      for (int b = 0; b < NB; b++) begin
        e.d = 8'((lane_st[l] >> (8 * b)) % 256);
        e.l = (l == 0) && (b == NB - 1);
        exp_q.push_back(e);
      end
    for (int i = 0; i < LANES; i++) lane_st[i] = M;
    lptr = 0;
  endtask

  // --- output ready driver ---
  initial forever begin
    @(posedge clk_i);
    #1;
    case (ready_mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = 1'($urandom_range(0, 1));
      default: m_ready_i = 1'b0;
    endcase
  end

  // --- monitor / scoreboard ---
  initial begin
    logic       hold_v;
    logic [7:0] hold_d;
    logic       hold_l;
    exp_t       e;
    hold_v = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("hold_valid", m_valid_o, 1);
          chk("hold_data", m_data_o, hold_d);
          chk("hold_last", m_last_o, hold_l);
        end
        if (m_valid_o && m_ready_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte actual=%0d required=none", m_data_o);
          end else begin
            e = exp_q.pop_front();
            if (m_data_o != e.d || m_last_o != e.l) begin
              errors++;
              $display("FAIL byte actual=%0d/last%0d required=%0d/last%0d",
                       m_data_o, m_last_o, e.d, e.l);
            end
          end
        end
        hold_v = m_valid_o && !m_ready_i;
        hold_d = m_data_o;
        hold_l = m_last_o;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // --- stimulus helpers ---
  task automatic do_reset();
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    flush_i   = 1'b0;
    freq_wr_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic write_freq(input int a, input int f, input int c);
    @(negedge clk_i);
    freq_wr_i   = 1'b1;
    freq_addr_i = 8'(a);
    freq_i      = 10'(f);
    cum_freq_i  = 10'(c);
    tf[a] = f;
    tc[a] = c;
    @(negedge clk_i);
    freq_wr_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_i);
    while (!s_ready_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    chk("wait_ready", s_ready_o, 1);
  endtask

  task automatic send_sym(input int s);
    wait_idle();
    s_valid_i = 1'b1;
    s_symb_i  = 8'(s);
    model_sym(s);
    @(negedge clk_i);
    s_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    int n;
    wait_idle();
    flush_i = 1'b1;
    model_flush();
    @(negedge clk_i);
    flush_i = 1'b0;
    n = 0;
    while (!done_o && n < 4000) begin
      @(negedge clk_i);
      n++;
    end
    chk("flush_done", done_o, 1);
    chk("flush_drained", exp_q.size(), 0);
    @(negedge clk_i);
    chk("done_pulse", done_o, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    int hs;
    int cum;
    int f;
    int s;
    for (int i = 0; i < 256; i++) begin
      tf[i] = 0;
      tc[i] = 0;
    end

    // reset state
    do_reset();
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_data", m_data_o, 0);
    chk("rst_m_last", m_last_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_s_ready", s_ready_o, 1);

    // single symbol, no renorm, 4-cycle symbol period
    write_freq(8'h41, 512, 0);
    send_sym(8'h41);
    k = 1;
    while (!s_ready_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    chk("ready_reassert_cycles", k, 4);
    for (int i = 0; i < 4; i++) send_sym(8'h41);
    drain();
    do_flush();

    // f=1 forces a renorm byte
    do_reset();
    write_freq(8'h07, 1, 5);
    send_sym(8'h07);
    drain();
    do_flush();

    // flush straight from reset
    do_reset();
    do_flush();

    // back-pressure hold on a renorm byte
    do_reset();
    ready_mode = 2;
    repeat (2) @(negedge clk_i);
    send_sym(8'h07);
    k = 0;
    while (!m_valid_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk("bp_valid_seen", m_valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", m_valid_o, 1);
      chk("bp_data", m_data_o,
          (exp_q.size() > 0) ? int'(exp_q[0].d) : 999);
      chk("bp_s_ready", s_ready_o, 0);
      @(negedge clk_i);
    end
    ready_mode = 0;
    drain();
    do_flush();

    // f=0 symbol: sticky error, no state change
    write_freq(8'h09, 0, 100);
    send_sym(8'h41);
    send_sym(8'h09);
    wait_idle();
    chk("err_set", err_o, err_exp);
    send_sym(8'h41);
    wait_idle();
    chk("err_sticky", err_o, err_exp);
    drain();

    // reset while flush byte 3 is on the bus
    wait_idle();
    flush_i = 1'b1;
    model_flush();
    @(negedge clk_i);
    flush_i = 1'b0;
    hs = 0;
    k  = 0;
    while (hs < 2 && k < 100) begin
      if (m_valid_o && m_ready_i) hs++;
      @(negedge clk_i);
      k++;
    end
    chk("byte3_presented", m_valid_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid_o, 0);
    chk("mid_rst_data", m_data_o, 0);
    chk("mid_rst_last", m_last_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_err", err_o, 0);
    do_reset();
    do_flush();

    // randomized traffic with random back-pressure
    do_reset();
    ready_mode = 1;
    cum = 0;
    for (int i = 0; i < 16; i++) begin
      f = $urandom_range(1, 60);
      write_freq(8'h80 + i, f, cum);
      cum += f;
    end
    for (int i = 0; i < 80; i++) begin
      if (i % 20 == 19) begin
        do_flush();
      end else begin
        k = $urandom_range(0, 19);
        if (k == 16) s = 8'h41;
        else if (k == 17) s = 8'h07;
        else s = 8'h80 + (k % 16);
        send_sym(s);
      end
    end
    do_flush();
    ready_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
